// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined immediate generator.
// Format codes and RV32I/RV64I opcode constants.
package imm_gen_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_SH   = 3'd6,
      FMT_Z    = 3'd7
   } imm_fmt_e;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decode: instruction -> XLEN immediate + format.
// SYSTEM/CSR immediates are decoded only with IMM_GEN_ZICSR_EN defined.
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm,
   output imm_fmt_e        fmt
);

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic            is_sh;
   logic            sh_hi;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] sh5;
   logic [XLEN-1:0] shx;

   assign opc   = inst[6:0];
   assign f3    = inst[14:12];
   assign is_sh = (f3 == 3'b001) || (f3 == 3'b101);
   // shamt bit 5 only exists on RV64; on RV32 it belongs to funct7
   assign sh_hi = (XLEN == 64) && inst[25];

   assign imm_i = XLEN'($signed(inst[31:20]));
   assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
   assign imm_b = XLEN'($signed({inst[31], inst[7],
                                 inst[30:25], inst[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({inst[31], inst[19:12],
                                 inst[20], inst[30:21], 1'b0}));
   assign sh5   = XLEN'(inst[24:20]);
   assign shx   = XLEN'({sh_hi, inst[24:20]});

   always_comb begin
      imm = '0;
      fmt = FMT_NONE;
      unique case (opc)
         OPC_LOAD, OPC_JALR: begin
            imm = imm_i;
            fmt = FMT_I;
         end
         OPC_OP_IMM: begin
            imm = is_sh ? shx : imm_i;
            fmt = is_sh ? FMT_SH : FMT_I;
         end
         OPC_OP_IMM32: begin
            if (XLEN == 64) begin
               imm = is_sh ? sh5 : imm_i;
               fmt = is_sh ? FMT_SH : FMT_I;
            end
         end
         OPC_STORE: begin
            imm = imm_s;
            fmt = FMT_S;
         end
         OPC_BRANCH: begin
            imm = imm_b;
            fmt = FMT_B;
         end
         OPC_LUI, OPC_AUIPC: begin
            imm = imm_u;
            fmt = FMT_U;
         end
         OPC_JAL: begin
            imm = imm_j;
            fmt = FMT_J;
         end
`ifdef IMM_GEN_ZICSR_EN
         OPC_SYSTEM: begin
            if (f3[2]) begin
               imm = XLEN'(inst[19:15]);
               fmt = FMT_Z;
            end else if (f3 != 3'b000) begin
               imm = XLEN'(inst[31:20]);
               fmt = FMT_I;
            end
         end
`endif
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with valid/ready and a one-deep skid entry.
// Optional CSR immediates: define IMM_GEN_ZICSR_EN.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic [TAG_W-1:0] out_tag
);

   typedef struct packed {
      logic [XLEN-1:0]  imm;
      imm_fmt_e         fmt;
      logic [TAG_W-1:0] tag;
   } entry_t;

   logic [XLEN-1:0] dec_imm;
   imm_fmt_e        dec_fmt;
   entry_t          in_e;

   entry_t out_q, out_d;
   entry_t skid_q, skid_d;
   logic   out_vld, out_vld_d;
   logic   skid_full, skid_full_d;
   logic   rdy_q, rdy_d;
   logic   accept, drain;

   imm_decode #(.XLEN(XLEN)) u_dec (
      .inst (in_inst),
      .imm  (dec_imm),
      .fmt  (dec_fmt)
   );

   assign in_e = '{imm: dec_imm, fmt: dec_fmt, tag: in_tag};

   assign accept = in_valid & rdy_q;
   assign drain  = out_vld & out_ready;

   always_comb begin
      out_d       = out_q;
      skid_d      = skid_q;
      out_vld_d   = out_vld;
      skid_full_d = skid_full;
      if (flush) begin
         out_vld_d   = 1'b0;
         skid_full_d = 1'b0;
      end else if (!out_vld || drain) begin
         // skid is older than anything arriving now; accept is
         // blocked while it is full, so no third slot is needed
         if (skid_full) begin
            out_d       = skid_q;
            out_vld_d   = 1'b1;
            skid_full_d = 1'b0;
         end else begin
            out_vld_d = accept;
            if (accept) begin
               out_d = in_e;
            end
         end
      end else if (accept) begin
         skid_d      = in_e;
         skid_full_d = 1'b1;
      end
      rdy_d = !skid_full_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q     <= '0;
         skid_q    <= '0;
         out_vld   <= 1'b0;
         skid_full <= 1'b0;
         rdy_q     <= 1'b1;
      end else begin
         out_q     <= out_d;
         skid_q    <= skid_d;
         out_vld   <= out_vld_d;
         skid_full <= skid_full_d;
         rdy_q     <= rdy_d;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = out_vld;
   assign out_imm   = out_q.imm;
   assign out_fmt   = out_q.fmt;
   assign out_tag   = out_q.tag;

endmodule
